rename_ctrl: RTL and testbench
==============================

RENAME_CTRL -- requirements
Module: rename_ctrl

Interface
REQ-001 Parameter PHYS_REG_SZ, 64, number of physical registers; TW = $clog2(PHYS_REG_SZ).
REQ-002 Parameter ARCH_REG_SZ, 32, number of architectural registers; free-list depth FL = PHYS_REG_SZ-ARCH_REG_SZ.
REQ-003 clock  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 disp_valid  in  1  rename request present.
REQ-006 disp_ready  out  1  request accepted when disp_valid && disp_ready.
REQ-007 disp_has_dest, disp_dest, disp_src1, disp_src2  in  1/5/5/5  dest-present flag and architectural register indices.
REQ-008 mt_cmd  out  2  map table command: 00 NOP, 01 READ, 10 WRITE.
REQ-009 mt_reg_t, mt_reg_t1, mt_reg_t2  out  5 each  map table dest/src1/src2 indices.
REQ-010 mt_t  out  TW+2  TAG {tag, valid, ready} written on WRITE.
REQ-011 mt_t_out, mt_t1_out, mt_t2_out  in  TW+2 each  map table read results, valid the cycle after READ.
REQ-012 ren_valid  out  1  one-cycle rename result strobe.
REQ-013 ren_tag, ren_told  out  TW each; ren_t1, ren_t2  out  TW+2 each  new dest tag, previous dest tag, source TAGs.
REQ-014 retire_valid, retire_told  in  1/TW  retiring instruction with dest; retire_told returned to free list.
REQ-015 flush  in  1  squash all unretired renames.
REQ-016 cdb_valid, cdb_tag  in  1/TW  CDB broadcast (used only under REQ-036).
REQ-017 fl_count  out  $clog2(FL+1)  free entries; err_overflow  out  1  sticky push-when-full flag.

Function
REQ-018 FSM states IDLE, READ, WRITE; IDLE->READ on accept; READ->WRITE unconditionally; WRITE->IDLE unconditionally; any state->IDLE on flush.
REQ-019 Accept cycle latches has_dest, dest, src1, src2 into internal registers.
REQ-020 disp_ready = (state==IDLE) && !flush && (!disp_has_dest || fl_count>0).
REQ-021 READ: mt_cmd=READ, mt_reg_t/t1/t2 = latched dest/src1/src2.
REQ-022 WRITE with has_dest: mt_cmd=WRITE, mt_reg_t=dest, mt_t={head tag, valid=1, ready=0}; free list pops head.
REQ-023 WRITE without has_dest: mt_cmd=NOP, no pop, ren_tag=0, ren_told=0.
REQ-024 WRITE: ren_valid=1, ren_tag=head tag, ren_told=mt_t_out.tag, ren_t1=mt_t1_out, ren_t2=mt_t2_out; accept-to-ren_valid latency 2 cycles, throughput 1 rename per 3 cycles.
REQ-025 mt_cmd=NOP and ren_valid=0 in IDLE; mt_* data outputs 0 when mt_cmd=NOP.
REQ-026 Free list: circular FIFO of FL TW-bit entries, head/tail pointers wrap modulo FL.
REQ-027 retire_valid pushes retire_told at tail, advances retire head rhead by 1, decrements inflight counter.
REQ-028 Pop (REQ-022) increments inflight; simultaneous pop and push leave fl_count unchanged.
REQ-029 retire_valid with fl_count==FL: push dropped, err_overflow set until reset; rhead/inflight still update.
REQ-030 flush: head<=rhead (after same-cycle retire), fl_count<=fl_count+inflight (after same-cycle retire), inflight<=0, state<=IDLE.
REQ-031 flush in WRITE: no pop, ren_valid=0, mt_cmd=NOP.

Reset
REQ-032 reset: state=IDLE, free list entry i = ARCH_REG_SZ+i, head=rhead=tail=0, fl_count=FL, inflight=0, err_overflow=0.
REQ-033 During and after reset cycle: disp_ready=0 on reset cycle, ren_valid=0, mt_cmd=NOP, all data outputs 0.
REQ-034 reset overrides flush, retire and dispatch in the same cycle, including mid-rename.

Configuration
REQ-035 Macro RENAME_CDB_BYPASS_EN selects CDB bypass.
REQ-036 Defined: in WRITE, if cdb_valid and cdb_tag equals ren_t1.tag (resp. ren_t2.tag) with valid=1, that output's ready bit forced to 1.
REQ-037 Undefined: cdb_valid/cdb_tag ignored; ren_t1/ren_t2 pass map table outputs unchanged.

Verification
REQ-038 Reset, dispatch dest=3 src1=1 src2=2 -> READ cycle+1, WRITE cycle+2 with mt_t.tag=32, ren_tag=32, fl_count 32->31.
REQ-039 32 back-to-back has_dest renames -> tags 32..63 in order, fl_count=0, disp_ready=0 for has_dest request, 1 for has_dest=0.
REQ-040 fl_count=0, retire_valid told=7 -> fl_count=1, next rename ren_tag=7 (wrap to entry 0).
REQ-041 Three renames, one retire, flush -> head=rhead, fl_count=FL-1+1 restored correctly, state IDLE; flush in WRITE -> no pop, ren_valid=0.
REQ-042 fl_count=FL plus retire_valid -> count stays FL, err_overflow=1 until reset.
REQ-043 RENAME_CDB_BYPASS_EN defined, mt_t1_out={9,1,0}, cdb_valid tag 9 in WRITE -> ren_t1.ready=1; undefined -> ready=0.

Source files
------------

// File: rtl/rename_ctrl.sv
// Register rename controller: IDLE/READ/WRITE against an external map table with a circular free list; accept-to-ren_valid 2 cycles, one rename per 3.
// disp_ready drops outside IDLE, on flush/reset, or when a dest needs a tag and none is free. Macro RENAME_CDB_BYPASS_EN enables CDB ready bypass on sources.
module rename_ctrl #(
  parameter int PHYS_REG_SZ = 64,
  parameter int ARCH_REG_SZ = 32,
  localparam int TW = $clog2(PHYS_REG_SZ),
  localparam int AW = $clog2(ARCH_REG_SZ),
  localparam int FL = PHYS_REG_SZ - ARCH_REG_SZ,
  localparam int CW = $clog2(FL + 1),
  localparam int PW = (FL > 1) ? $clog2(FL) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          disp_valid,
  output logic          disp_ready,
  input  logic          disp_has_dest,
  input  logic [AW-1:0] disp_dest,
  input  logic [AW-1:0] disp_src1,
  input  logic [AW-1:0] disp_src2,
  output logic [1:0]    mt_cmd,
  output logic [AW-1:0] mt_reg_t,
  output logic [AW-1:0] mt_reg_t1,
  output logic [AW-1:0] mt_reg_t2,
  output logic [TW+1:0] mt_t,
  input  logic [TW+1:0] mt_t_out,
  input  logic [TW+1:0] mt_t1_out,
  input  logic [TW+1:0] mt_t2_out,
  output logic          ren_valid,
  output logic [TW-1:0] ren_tag,
  output logic [TW-1:0] ren_told,
  output logic [TW+1:0] ren_t1,
  output logic [TW+1:0] ren_t2,
  input  logic          retire_valid,
  input  logic [TW-1:0] retire_told,
  input  logic          flush,
  input  logic          cdb_valid,
  input  logic [TW-1:0] cdb_tag,
  output logic [CW-1:0] fl_count,
  output logic          err_overflow
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

  localparam logic [1:0] MT_NOP   = 2'b00;
  localparam logic [1:0] MT_READ  = 2'b01;
  localparam logic [1:0] MT_WRITE = 2'b10;

  state_t        state, state_nxt;
  logic          has_q;
  logic [AW-1:0] dest_q, src1_q, src2_q;
  logic [TW-1:0] fl_mem [FL];
  logic [PW-1:0] head, tail, rhead, rhead_nxt;
  logic [CW-1:0] inflight, infl_nxt, cnt_nxt;
  logic [TW-1:0] head_tag;
  logic          accept, pop, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FL - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_tag   = fl_mem[head];
  assign disp_ready = (state == IDLE) && !flush && !reset && (!disp_has_dest || fl_count != '0);
  assign accept     = disp_valid && disp_ready;
  assign pop        = (state == WRITE) && !flush && has_q;
  assign push       = retire_valid && (fl_count != CW'(FL));

  // Retire always advances rhead and drains inflight, even when the push itself is dropped.
  always_comb begin
    rhead_nxt = retire_valid ? ptr_inc(rhead) : rhead;
    infl_nxt  = inflight + CW'(pop);
    if (retire_valid && infl_nxt != '0) infl_nxt = infl_nxt - 1'b1;
    cnt_nxt   = fl_count + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_nxt = state;
    mt_cmd    = MT_NOP;
    mt_reg_t  = '0;
    mt_reg_t1 = '0;
    mt_reg_t2 = '0;
    mt_t      = '0;
    ren_valid = 1'b0;
    ren_tag   = '0;
    ren_told  = '0;
    ren_t1    = '0;
    ren_t2    = '0;
    case (state)
      IDLE: if (accept) state_nxt = READ;
      READ: begin
        state_nxt = WRITE;
        if (!reset) begin
          mt_cmd    = MT_READ;
          mt_reg_t  = dest_q;
          mt_reg_t1 = src1_q;
          mt_reg_t2 = src2_q;
        end
      end
      WRITE: begin
        state_nxt = IDLE;
        if (!reset && !flush) begin
          ren_valid = 1'b1;
          ren_t1    = mt_t1_out;
          ren_t2    = mt_t2_out;
`ifdef RENAME_CDB_BYPASS_EN
          if (cdb_valid && mt_t1_out[1] && cdb_tag == mt_t1_out[TW+1:2]) ren_t1[0] = 1'b1;
          if (cdb_valid && mt_t2_out[1] && cdb_tag == mt_t2_out[TW+1:2]) ren_t2[0] = 1'b1;
`endif
          if (has_q) begin
            mt_cmd   = MT_WRITE;
            mt_reg_t = dest_q;
            mt_t     = {head_tag, 2'b10};
            ren_tag  = head_tag;
            ren_told = mt_t_out[TW+1:2];
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

`ifndef RENAME_CDB_BYPASS_EN
  logic unused_cdb;
  assign unused_cdb = ^{cdb_valid, cdb_tag};
`endif
  logic unused_told_flags;
  assign unused_told_flags = ^mt_t_out[1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      has_q        <= 1'b0;
      dest_q       <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      head         <= '0;
      tail         <= '0;
      rhead        <= '0;
      fl_count     <= CW'(FL);
      inflight     <= '0;
      err_overflow <= 1'b0;
      for (int i = 0; i < FL; i++) fl_mem[i] <= TW'(ARCH_REG_SZ + i);
    end else begin
      state <= state_nxt;
      if (accept) begin
        has_q  <= disp_has_dest;
        dest_q <= disp_dest;
        src1_q <= disp_src1;
        src2_q <= disp_src2;
      end
      if (push) begin
        fl_mem[tail] <= retire_told;
        tail         <= ptr_inc(tail);
      end
      if (retire_valid && !push) err_overflow <= 1'b1;
      rhead <= rhead_nxt;
      // Flush rewinds head to the oldest unretired pop and returns those tags.
      if (flush) begin
        head     <= rhead_nxt;
        fl_count <= cnt_nxt + infl_nxt;
        inflight <= '0;
      end else begin
        if (pop) head <= ptr_inc(head);
        fl_count <= cnt_nxt;
        inflight <= infl_nxt;
      end
    end
  end

endmodule

// File: tb/tb_rename_ctrl.sv
// Self-checking bench for rename_ctrl: queue-based free-list model, directed scenarios, then randomized traffic.
module tb_rename_ctrl;
  localparam int ARCH = 32;
  localparam int FL   = 32;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       disp_valid = 1'b0, disp_ready, disp_has_dest = 1'b0;
  logic [4:0] disp_dest = '0, disp_src1 = '0, disp_src2 = '0;
  logic [1:0] mt_cmd;
  logic [4:0] mt_reg_t, mt_reg_t1, mt_reg_t2;
  logic [7:0] mt_t, mt_t_out = '0, mt_t1_out = '0, mt_t2_out = '0;
  logic       ren_valid;
  logic [5:0] ren_tag, ren_told;
  logic [7:0] ren_t1, ren_t2;
  logic       retire_valid = 1'b0;
  logic [5:0] retire_told = '0;
  logic       flush = 1'b0, cdb_valid = 1'b0;
  logic [5:0] cdb_tag = '0;
  logic [5:0] fl_count;
  logic       err_overflow;

  rename_ctrl dut (
    .clock(clock), .reset(reset), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_has_dest(disp_has_dest), .disp_dest(disp_dest), .disp_src1(disp_src1), .disp_src2(disp_src2),
    .mt_cmd(mt_cmd), .mt_reg_t(mt_reg_t), .mt_reg_t1(mt_reg_t1), .mt_reg_t2(mt_reg_t2), .mt_t(mt_t),
    .mt_t_out(mt_t_out), .mt_t1_out(mt_t1_out), .mt_t2_out(mt_t2_out),
    .ren_valid(ren_valid), .ren_tag(ren_tag), .ren_told(ren_told), .ren_t1(ren_t1), .ren_t2(ren_t2),
    .retire_valid(retire_valid), .retire_told(retire_told), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .fl_count(fl_count), .err_overflow(err_overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: phase of the pending rename, free tags in pop order, popped-but-unretired tags.
  int         ph;
  bit         m_has;
  logic [4:0] m_dest, m_s1, m_s2;
  logic [5:0] fq[$];
  logic [5:0] ifq[$];
  bit         m_err;
  bit         armed = 1'b0;
  bit         last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0;
    m_has = 1'b0;
    fq.delete();
    ifq.delete();
    for (int i = 0; i < FL; i++) fq.push_back(6'(ARCH + i));
    m_err = 1'b0;
  endtask

  task automatic step();
    logic       e_ready, e_rv, full, pop;
    logic [1:0] e_cmd;
    logic [4:0] e_rt, e_r1, e_r2;
    logic [7:0] e_mt, e_t1, e_t2;
    logic [5:0] e_tag, e_told, t;
    #1;
    e_ready = (ph == 0) && !flush && !reset && (!disp_has_dest || fq.size() > 0);
    e_rv = 0; e_cmd = 0; e_rt = 0; e_r1 = 0; e_r2 = 0; e_mt = 0; e_t1 = 0; e_t2 = 0; e_tag = 0; e_told = 0;
    if (!reset && ph == 1) begin
      e_cmd = 2'b01; e_rt = m_dest; e_r1 = m_s1; e_r2 = m_s2;
    end
    if (!reset && ph == 2 && !flush) begin
      e_rv = 1; e_t1 = mt_t1_out; e_t2 = mt_t2_out;
`ifdef RENAME_CDB_BYPASS_EN
      if (cdb_valid && e_t1[1] && cdb_tag == e_t1[7:2]) e_t1[0] = 1'b1;
      if (cdb_valid && e_t2[1] && cdb_tag == e_t2[7:2]) e_t2[0] = 1'b1;
`endif
      if (m_has && fq.size() > 0) begin
        e_cmd = 2'b10; e_rt = m_dest; e_mt = {fq[0], 2'b10}; e_tag = fq[0]; e_told = mt_t_out[7:2];
      end
    end
    if (armed) begin
      chk("disp_ready", disp_ready, e_ready);
      chk("mt_cmd", mt_cmd, e_cmd);
      chk("mt_reg_t", mt_reg_t, e_rt);
      chk("mt_reg_t1", mt_reg_t1, e_r1);
      chk("mt_reg_t2", mt_reg_t2, e_r2);
      chk("mt_t", mt_t, e_mt);
      chk("ren_valid", ren_valid, e_rv);
      chk("ren_tag", ren_tag, e_tag);
      chk("ren_told", ren_told, e_told);
      chk("ren_t1", ren_t1, e_t1);
      chk("ren_t2", ren_t2, e_t2);
      chk("fl_count", fl_count, fq.size());
      chk("err_overflow", err_overflow, m_err);
    end
    last_acc = disp_valid && e_ready;
    if (reset) begin
      model_reset();
    end else begin
      full = (fq.size() == FL);
      pop  = (ph == 2) && !flush && m_has;
      if (pop) begin
        t = fq.pop_front();
        ifq.push_back(t);
      end
      if (retire_valid) begin
        if (ifq.size() > 0) void'(ifq.pop_front());
        if (full) m_err = 1'b1;
        else fq.push_back(retire_told);
      end
      if (flush) begin
        fq = {ifq, fq};
        ifq.delete();
        ph = 0;
      end else if (ph == 0) begin
        if (last_acc) begin
          ph = 1; m_has = disp_has_dest; m_dest = disp_dest; m_s1 = disp_src1; m_s2 = disp_src2;
        end
      end else if (ph == 1) ph = 2;
      else ph = 0;
    end
    @(negedge clock);
  endtask

  task automatic rename_to_write(input bit has, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    int n = 0;
    disp_valid = 1'b1; disp_has_dest = has; disp_dest = d; disp_src1 = s1; disp_src2 = s2;
    do begin
      step();
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no accept after %0d cycles, required accept", n);
    end
    disp_valid = 1'b0;
    step();
  endtask

  task automatic rename(input bit has, input logic [4:0] d, output logic [5:0] tag);
    rename_to_write(has, d, 5'(d + 1), 5'(d + 2));
    #1 tag = ren_tag;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1; disp_valid = 1'b1; disp_has_dest = 1'b1;
    step();
    #1;
    chk("reset_ready", disp_ready, 0);
    chk("reset_count", fl_count, FL);
    chk("reset_cmd", mt_cmd, 0);
    step();
    reset = 1'b0; disp_valid = 1'b0;
  endtask

  initial begin
    logic [5:0] tag;
    logic       exp_byp;
    model_reset();
    @(negedge clock);
    step();
    armed = 1'b1;
    do_reset();

    // Single rename: READ then WRITE with the first free tag
    disp_valid = 1'b1; disp_has_dest = 1'b1; disp_dest = 5'd3; disp_src1 = 5'd1; disp_src2 = 5'd2;
    step();
    disp_valid = 1'b0;
    #1;
    chk("read_cmd", mt_cmd, 2'b01);
    chk("read_reg_t", mt_reg_t, 3);
    chk("read_reg_t1", mt_reg_t1, 1);
    chk("read_reg_t2", mt_reg_t2, 2);
    step();
    #1;
    chk("write_cmd", mt_cmd, 2'b10);
    chk("write_mt_tag", mt_t[7:2], 32);
    chk("write_ren_tag", ren_tag, 32);
    chk("write_ren_valid", ren_valid, 1);
    step();
    #1 chk("count_after_one", fl_count, 31);

    // Drain the free list back to back
    for (int i = 1; i < 32; i++) begin
      rename(1'b1, 5'(i), tag);
      chk("b2b_tag", tag, 32 + i);
    end
    #1 chk("count_empty", fl_count, 0);
    disp_has_dest = 1'b1;
    #1 chk("ready_dest_empty", disp_ready, 0);
    disp_has_dest = 1'b0;
    #1 chk("ready_nodest_empty", disp_ready, 1);
    step();
    rename(1'b0, 5'd4, tag);
    chk("nodest_tag", tag, 0);

    // Retire into an empty list, then reuse through the wrapped head
    retire_valid = 1'b1; retire_told = 6'd7;
    step();
    retire_valid = 1'b0;
    #1 chk("count_after_retire", fl_count, 1);
    rename(1'b1, 5'd9, tag);
    chk("wrap_tag", tag, 7);

    // Flush restores unretired tags
    do_reset();
    for (int i = 0; i < 3; i++) rename(1'b1, 5'(i + 10), tag);
    retire_valid = 1'b1; retire_told = 6'd40;
    step();
    retire_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    #1 chk("flush_count", fl_count, 32);
    rename(1'b1, 5'd5, tag);
    chk("flush_head_tag", tag, 33);
    rename_to_write(1'b1, 5'd6, 5'd7, 5'd8);
    flush = 1'b1;
    #1;
    chk("flush_write_valid", ren_valid, 0);
    chk("flush_write_cmd", mt_cmd, 0);
    step();
    flush = 1'b0;
    #1 chk("flush_write_count", fl_count, 32);
    rename(1'b1, 5'd6, tag);
    chk("flush_write_tag", tag, 33);

    // Push into a full list
    do_reset();
    retire_valid = 1'b1; retire_told = 6'd5;
    step();
    retire_valid = 1'b0;
    #1;
    chk("ovf_count", fl_count, 32);
    chk("ovf_flag", err_overflow, 1);
    for (int i = 0; i < 3; i++) step();
    #1 chk("ovf_sticky", err_overflow, 1);
    do_reset();
    #1 chk("ovf_cleared", err_overflow, 0);

    // CDB bypass on source 1
    mt_t1_out = {6'd9, 2'b10};
    rename_to_write(1'b1, 5'd1, 5'd2, 5'd3);
    cdb_valid = 1'b1; cdb_tag = 6'd9;
`ifdef RENAME_CDB_BYPASS_EN
    exp_byp = 1'b1;
`else
    exp_byp = 1'b0;
`endif
    #1 chk("cdb_bypass_ready", ren_t1[0], exp_byp);
    step();
    cdb_valid = 1'b0; mt_t1_out = '0;

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      disp_valid    = 1'($urandom_range(0, 1));
      disp_has_dest = ($urandom_range(0, 3) != 0);
      disp_dest     = 5'($urandom_range(0, 31));
      disp_src1     = 5'($urandom_range(0, 31));
      disp_src2     = 5'($urandom_range(0, 31));
      mt_t_out      = 8'($urandom_range(0, 255));
      mt_t1_out     = 8'($urandom_range(0, 255));
      mt_t2_out     = 8'($urandom_range(0, 255));
      cdb_valid     = 1'($urandom_range(0, 1));
      cdb_tag       = ($urandom_range(0, 1) == 1) ? mt_t1_out[7:2] : mt_t2_out[7:2];
      retire_valid  = (ifq.size() > 0) && ($urandom_range(0, 3) == 0);
      retire_told   = 6'($urandom_range(0, 63));
      flush         = ($urandom_range(0, 29) == 0);
      reset         = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0; flush = 1'b0; retire_valid = 1'b0; disp_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
